// File: rtl/wb_pkg.sv
// Shared definitions for the register writeback stage.
// Holds the default widths and depth, the function that sizes the
// buffered-load counter, and the arbitration selection encoding.
package wb_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Counter must represent 0..depth inclusive, hence the extra bit.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_MEM
  } sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer for the writeback stage.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   push, push_data  write an entry (ignored when full)
//   pop, pop_data    remove the head entry (ignored when empty); pop_data
//                    always shows the current head
//   full, empty      status derived from the registered count
//   count            number of stored entries
module wb_fifo
  import wb_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [count_w(DEPTH)-1:0]   count
);

  localparam int CW = count_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push)
      storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register writeback stage: arbitrates ALU results against buffered load
// results into a single register-file write port and keeps a per-register
// pending scoreboard.
// Ports:
//   CLK, RST_N                         clock, asynchronous active-low reset
//   alu_valid/alu_dest/alu_result      ALU result, highest priority
//   mem_valid/mem_ready/mem_dest/mem_data  load result handshake
//   issue_valid/issue_dest             marks a destination pending
//   RegWrite/writeReg/writeValue       registered register-file write
//   busy                               pending bit per register
//   fifo_count                         buffered load entries
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             alu_valid,
  input  logic [ADDR_W-1:0]                alu_dest,
  input  logic [DATA_W-1:0]                alu_result,
  input  logic                             mem_valid,
  output logic                             mem_ready,
  input  logic [ADDR_W-1:0]                mem_dest,
  input  logic [DATA_W-1:0]                mem_data,
  input  logic                             issue_valid,
  input  logic [ADDR_W-1:0]                issue_dest,
  output logic                             RegWrite,
  output logic [ADDR_W-1:0]                writeReg,
  output logic [DATA_W-1:0]                writeValue,
  output logic [(2**ADDR_W)-1:0]           busy,
  output logic [count_w(FIFO_DEPTH)-1:0]   fifo_count
);

  localparam int NREG = 2**ADDR_W;
  localparam int EW   = ADDR_W + DATA_W;

  sel_e              sel;
  logic [ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0] sel_data;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [NREG-1:0]   busy_next;

  // Loads always go through the buffer, so a load is never written in the
  // cycle it is accepted.
  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (mem_valid),
    .push_data ({mem_dest, mem_data}),
    .pop       (sel == SEL_MEM),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_ready = !fifo_full;

  // Fixed priority: the ALU has no backpressure so it always wins.
  always_comb begin
    sel      = SEL_NONE;
    sel_dest = '0;
    sel_data = '0;
    if (alu_valid) begin
      sel      = SEL_ALU;
      sel_dest = alu_dest;
      sel_data = alu_result;
    end else if (!fifo_empty) begin
      sel      = SEL_MEM;
      sel_dest = head[EW-1:DATA_W];
      sel_data = head[DATA_W-1:0];
    end
  end

  // Register 0 is hardwired: results aimed at it are consumed without a
  // write enable, but the index/value registers still track them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWrite   <= 1'b0;
      writeReg   <= '0;
      writeValue <= '0;
    end else if (sel != SEL_NONE) begin
      RegWrite   <= (sel_dest != '0);
      writeReg   <= sel_dest;
      writeValue <= sel_data;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  // Clear for the retiring destination first, then set for the new issue,
  // so a simultaneous set/clear of one bit leaves it pending.
  always_comb begin
    busy_next = busy;
    if (sel != SEL_NONE)
      busy_next[sel_dest] = 1'b0;
    if (issue_valid)
      busy_next[issue_dest] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      busy <= '0;
    else
      busy <= busy_next;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a table of per-cycle vectors with
// hand-computed expectations, plus directed sequences for FIFO fill/drain
// and reset in the middle of activity.
module tb_reg_writeback;

  logic        CLK;
  logic        RST_N;
  logic        alu_valid;
  logic [2:0]  alu_dest;
  logic [15:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic        RegWrite;
  logic [2:0]  writeReg;
  logic [15:0] writeValue;
  logic [7:0]  busy;
  logic [2:0]  fifo_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        alu_v;
    logic [2:0]  alu_d;
    logic [15:0] alu_r;
    logic        mem_v;
    logic [2:0]  mem_d;
    logic [15:0] mem_dt;
    logic        iss_v;
    logic [2:0]  iss_d;
    logic        e_rw;
    logic [2:0]  e_wr;
    logic [15:0] e_wv;
    logic [7:0]  e_busy;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [15];

  reg_writeback dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .alu_valid   (alu_valid),
    .alu_dest    (alu_dest),
    .alu_result  (alu_result),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_dest    (mem_dest),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .RegWrite    (RegWrite),
    .writeReg    (writeReg),
    .writeValue  (writeValue),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input int av, input int ad, input int ar,
                              input int mv, input int md, input int mdt,
                              input int iv, input int id,
                              input int rw, input int wr, input int wv,
                              input int bz, input int cn, input int rd);
    vec_t v;
    v.alu_v  = 1'(av);
    v.alu_d  = 3'(ad);
    v.alu_r  = 16'(ar);
    v.mem_v  = 1'(mv);
    v.mem_d  = 3'(md);
    v.mem_dt = 16'(mdt);
    v.iss_v  = 1'(iv);
    v.iss_d  = 3'(id);
    v.e_rw   = 1'(rw);
    v.e_wr   = 3'(wr);
    v.e_wv   = 16'(wv);
    v.e_busy = 8'(bz);
    v.e_cnt  = 3'(cn);
    v.e_rdy  = 1'(rd);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    alu_valid   = v.alu_v;
    alu_dest    = v.alu_d;
    alu_result  = v.alu_r;
    mem_valid   = v.mem_v;
    mem_dest    = v.mem_d;
    mem_data    = v.mem_dt;
    issue_valid = v.iss_v;
    issue_dest  = v.iss_d;
  endtask

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic rw,
                             input logic [2:0] wr, input logic [15:0] wv,
                             input logic [7:0] bz, input logic [2:0] cn,
                             input logic rd);
    checkField({tag, ".RegWrite"},   32'(RegWrite),   32'(rw));
    checkField({tag, ".writeReg"},   32'(writeReg),   32'(wr));
    checkField({tag, ".writeValue"}, 32'(writeValue), 32'(wv));
    checkField({tag, ".busy"},       32'(busy),       32'(bz));
    checkField({tag, ".fifo_count"}, 32'(fifo_count), 32'(cn));
    checkField({tag, ".mem_ready"},  32'(mem_ready),  32'(rd));
  endtask

  initial begin
    //          alu v,d,r           mem v,d,data       iss v,d  exp rw,wr,wv       busy cnt rdy
    vecs[0]  = mk(1, 3, 'hABCD,     0, 0, 0,           0, 0,    1, 3, 'hABCD,      'h00, 0, 1);
    vecs[1]  = mk(0, 0, 0,          0, 0, 0,           0, 0,    0, 3, 'hABCD,      'h00, 0, 1);
    vecs[2]  = mk(0, 0, 0,          1, 2, 'h00A7,      0, 0,    0, 3, 'hABCD,      'h00, 1, 1);
    vecs[3]  = mk(0, 0, 0,          0, 0, 0,           0, 0,    1, 2, 'h00A7,      'h00, 0, 1);
    vecs[4]  = mk(1, 0, 'h2030,     0, 0, 0,           0, 0,    0, 0, 'h2030,      'h00, 0, 1);
    vecs[5]  = mk(0, 0, 0,          0, 0, 0,           1, 6,    0, 0, 'h2030,      'h40, 0, 1);
    vecs[6]  = mk(1, 6, 'h5555,     0, 0, 0,           1, 6,    1, 6, 'h5555,      'h40, 0, 1);
    vecs[7]  = mk(1, 6, 'h6666,     0, 0, 0,           0, 0,    1, 6, 'h6666,      'h00, 0, 1);
    vecs[8]  = mk(0, 0, 0,          0, 0, 0,           1, 0,    0, 6, 'h6666,      'h00, 0, 1);
    vecs[9]  = mk(0, 0, 0,          1, 5, 'h1234,      1, 1,    0, 6, 'h6666,      'h02, 1, 1);
    vecs[10] = mk(1, 1, 'h0F0F,     1, 4, 'h4444,      0, 0,    1, 1, 'h0F0F,      'h00, 2, 1);
    vecs[11] = mk(0, 0, 0,          0, 0, 0,           0, 0,    1, 5, 'h1234,      'h00, 1, 1);
    vecs[12] = mk(0, 0, 0,          1, 7, 'h7777,      0, 0,    1, 4, 'h4444,      'h00, 1, 1);
    vecs[13] = mk(0, 0, 0,          0, 0, 0,           0, 0,    1, 7, 'h7777,      'h00, 0, 1);
    vecs[14] = mk(0, 0, 0,          0, 0, 0,           0, 0,    0, 7, 'h7777,      'h00, 0, 1);

    RST_N = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    checkOutput("reset", 1'b0, 3'd0, 16'h0000, 8'h00, 3'd0, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wr,
                  vecs[i].e_wv, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_rdy);
    end

    $display("[TB] fill/drain under ALU pressure");
    for (int i = 0; i < 6; i++) begin
      alu_valid   = 1'b1;
      alu_dest    = 3'd1;
      alu_result  = 16'(16'h1000 + i);
      mem_valid   = (i < 5);
      mem_dest    = 3'(i + 2);
      mem_data    = 16'(16'h00A0 + i);
      issue_valid = 1'b0;
      issue_dest  = 3'd0;
      checkField($sformatf("fill%0d.mem_ready_pre", i), 32'(mem_ready),
                 32'((i < 4) ? 1 : 0));
      @(posedge CLK);
      #1;
      checkOutput($sformatf("fill%0d", i), 1'b1, 3'd1, 16'(16'h1000 + i),
                  8'h00, 3'((i < 4) ? i + 1 : 4), (i >= 3) ? 1'b0 : 1'b1);
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("drain%0d", k), 1'b1, 3'(k + 2),
                  16'(16'h00A0 + k), 8'h00, 3'(3 - k), 1'b1);
    end
    @(posedge CLK);
    #1;
    checkOutput("drain_end", 1'b0, 3'd5, 16'h00A3, 8'h00, 3'd0, 1'b1);

    $display("[TB] reset with buffered loads and pending registers");
    for (int j = 0; j < 3; j++) begin
      alu_valid   = 1'b1;
      alu_dest    = 3'd1;
      alu_result  = 16'h0001;
      mem_valid   = 1'b1;
      mem_dest    = 3'd3;
      mem_data    = 16'h0333;
      issue_valid = (j < 2);
      issue_dest  = (j == 0) ? 3'd2 : 3'd6;
      @(posedge CLK);
      #1;
    end
    checkOutput("pre_reset", 1'b1, 3'd1, 16'h0001, 8'h44, 3'd3, 1'b1);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    RST_N = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 3'd0, 16'h0000, 8'h00, 3'd0, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("post_reset%0d", j), 1'b0, 3'd0, 16'h0000,
                  8'h00, 3'd0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
